// File: rtl/key_pkg.sv
// Shared definitions for the key loader: parameter defaults and FSM state encoding.
package key_pkg;

    localparam int unsigned KEY_W_DEF     = 8;
    localparam int unsigned TIMEOUT_DEF   = 64;
    localparam int unsigned MAX_RETRY_DEF = 3;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StArmed,
        StError,
        StLockout
    } state_e;

endpackage

// File: rtl/key_loader_if.sv
// Serial key input and key delivery signals between the key loader and its environment.
interface key_loader_if import key_pkg::*; #(
    parameter int unsigned KEY_W = KEY_W_DEF
) ();

    logic             start;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] keyinput;
    logic             key_ok;
    logic             fsm_rst;
    logic             err;

    modport master (
        output start, ser_valid, ser_data,
        input  ser_ready, keyinput, key_ok, fsm_rst, err
    );

    modport slave (
        input  start, ser_valid, ser_data,
        output ser_ready, keyinput, key_ok, fsm_rst, err
    );

endinterface

// File: rtl/key_shift_rx.sv
// Serial accumulator: LSB-first key shift register, bit counter and running even parity
// over the key bits plus the trailing parity bit.
module key_shift_rx import key_pkg::*; #(
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic             data,
    output logic [KEY_W-1:0] key,
    output logic             full,
    output logic             parity_ok
);

    localparam int unsigned CW = $clog2(KEY_W + 2);

    logic [KEY_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             par_q, par_d;

    always_comb begin
        sreg_d  = sreg_q;
        count_d = count_q;
        par_d   = par_q;
        if (clear) begin
            sreg_d  = '0;
            count_d = '0;
            par_d   = 1'b0;
        end else if (accept) begin
            // Right-shifting KEY_W times lands the first bit at position 0.
            if (count_q < CW'(KEY_W)) begin
                sreg_d = {data, sreg_q[KEY_W-1:1]};
            end
            count_d = count_q + CW'(1);
            par_d   = par_q ^ data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg_q  <= '0;
            count_q <= '0;
            par_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            count_q <= count_d;
            par_q   <= par_d;
        end
    end

    assign key       = sreg_q;
    assign full      = (count_q == CW'(KEY_W));
    assign parity_ok = !par_q;

endmodule

// File: rtl/key_loader.sv
// Loads a parity-protected serial key and delivers it to a locked FSM, with an idle
// timeout, a bounded number of retries and a sticky lockout.
module key_loader import key_pkg::*; #(
    parameter int unsigned KEY_W     = KEY_W_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input logic         clk,
    input logic         rst,
    key_loader_if.slave bus
);

    localparam int unsigned    TW          = $clog2(TIMEOUT + 1);
    localparam int unsigned    RW          = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0]  TimeoutLast = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]  RetryMax    = RW'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [TW-1:0]    timeout_q, timeout_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             accept, rx_clear, rx_full, parity_ok;
    logic [KEY_W-1:0] rx_key;

    assign accept = (state_q == StShift) && bus.ser_valid;

    key_shift_rx #(
        .KEY_W (KEY_W)
    ) u_shift_rx (
        .clk       (clk),
        .rst       (rst),
        .clear     (rx_clear),
        .accept    (accept),
        .data      (bus.ser_data),
        .key       (rx_key),
        .full      (rx_full),
        .parity_ok (parity_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        retry_d   = retry_q;
        key_d     = key_q;
        rx_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StShift;
                    timeout_d = '0;
                    rx_clear  = 1'b1;
                end
            end
            StShift: begin
                if (accept) begin
                    timeout_d = '0;
                    if (rx_full) begin
                        state_d = StCheck;
                    end
                end else if (timeout_q == TimeoutLast) begin
                    state_d = StError;
                    retry_d = retry_q + RW'(1);
                end else begin
                    timeout_d = timeout_q + TW'(1);
                end
            end
            StCheck: begin
                if (parity_ok) begin
                    state_d = StArmed;
                    key_d   = rx_key;
                end else begin
                    state_d = StError;
                    retry_d = retry_q + RW'(1);
                end
            end
            StError: begin
                if (retry_q >= RetryMax) begin
                    state_d = StLockout;
                end else if (bus.start) begin
                    state_d   = StShift;
                    timeout_d = '0;
                    rx_clear  = 1'b1;
                end
            end
            StArmed, StLockout: begin
                state_d = state_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // key_q is loaded only on entry to ARMED, which is left only through reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_q <= '0;
            retry_q   <= '0;
            key_q     <= '0;
        end else begin
            timeout_q <= timeout_d;
            retry_q   <= retry_d;
            key_q     <= key_d;
        end
    end

    always_comb begin
        bus.ser_ready = (state_q == StShift);
        bus.key_ok    = (state_q == StArmed);
        bus.fsm_rst   = (state_q != StArmed);
        bus.err       = (state_q == StError) || (state_q == StLockout);
        bus.keyinput  = key_q;
    end

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader: stimulus queues expected output tuples, a negedge
// monitor pops one whenever the outputs change or a probe is requested.
module tb_key_loader;
    import key_pkg::*;

    typedef logic [11:0] tup_t;
    typedef struct {
        tup_t  val;
        int    cyc;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   probe_req = 0;
    int   probe_ack = 0;
    int   last_cyc = 0;
    tup_t exp_last = 'x;
    tup_t prev = 'x;
    exp_t q[$];

    key_loader_if #(.KEY_W(8)) bus ();

    key_loader #(
        .KEY_W     (8),
        .TIMEOUT   (64),
        .MAX_RETRY (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic tup_t tup(input logic [7:0] k, input logic ok, input logic frst,
                                 input logic e, input logic rdy);
        return {k, ok, frst, e, rdy};
    endfunction

    localparam tup_t TIdle  = 12'b0000_0000_0100;
    localparam tup_t TShift = 12'b0000_0000_0101;
    localparam tup_t TErr   = 12'b0000_0000_0110;

    // Monitor: compare on every output change or explicit probe.
    always @(negedge clk) begin
        tup_t cur;
        exp_t e;
        cur = {bus.keyinput, bus.key_ok, bus.fsm_rst, bus.err, bus.ser_ready};
        if (cur !== prev || probe_req != probe_ack) begin
            probe_ack = probe_req;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got %h at cycle %0d, want no change", cur, cyc);
            end else begin
                e = q.pop_front();
                if (cur !== e.val || (e.cyc >= 0 && cyc != e.cyc)) begin
                    miscompares++;
                    $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                             e.name, cur, cyc, e.val, e.cyc);
                end
            end
        end
        prev = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input tup_t t, input int c, input string nm);
        if (t !== exp_last) begin
            q.push_back('{t, c, nm});
            exp_last = t;
        end
    endtask

    task automatic expect_probe(input tup_t t, input string nm);
        q.push_back('{t, -1, nm});
        exp_last = t;
        probe_req++;
        tick();
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        expect_out(TIdle, -1, nm);
        tick();
        rst = 1'b1;
    endtask

    task automatic start_pulse(input tup_t t, input string nm);
        bus.start = 1'b1;
        expect_out(t, -1, nm);
        tick();
        bus.start = 1'b0;
    endtask

    // mode: 0 no response expected, 1 good parity, 2 bad parity
    task automatic send_frame(input logic [8:0] frame, input int nbits, input int mode,
                              input int start_at, input string nm);
        for (int i = 0; i < nbits; i++) begin
            bus.ser_valid = 1'b1;
            bus.ser_data  = frame[i];
            bus.start     = (i == start_at);
            last_cyc      = cyc;
            if (i == nbits - 1 && mode != 0) begin
                expect_out(TIdle, cyc + 1, {nm, "_check"});
                if (mode == 1) expect_out(tup(frame[7:0], 1'b1, 1'b0, 1'b0, 1'b0), cyc + 2,
                                          {nm, "_armed"});
                else expect_out(TErr, cyc + 2, {nm, "_err"});
            end
            tick();
        end
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        bus.start     = 1'b0;
        if (nbits == 9) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        expect_out(TIdle, -1, "reset_state");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Good load of 0xA5; a start mid-shift must be ignored.
        start_pulse(TShift, "a5_shift");
        send_frame({1'b0, 8'hA5}, 9, 1, 3, "a5");
        tick();

        // Bad parity, then retry with 0x3C.
        do_reset("rst_2");
        tick();
        start_pulse(TShift, "bad_shift");
        send_frame({1'b1, 8'hA5}, 9, 2, -1, "bad_a5");
        start_pulse(TShift, "retry_shift");
        send_frame({1'b0, 8'h3C}, 9, 1, -1, "3c");
        tick();

        // Idle timeout after five bits.
        do_reset("rst_3");
        start_pulse(TShift, "to_shift");
        send_frame({1'b0, 8'hA5}, 5, 0, -1, "to");
        expect_out(TErr, last_cyc + 65, "timeout_err");
        repeat (70) tick();
        expect_probe(TErr, "timeout_hold");

        // Three bad loads lead to lockout; a later valid load changes nothing.
        do_reset("rst_4");
        for (int n = 0; n < 3; n++) begin
            start_pulse(TShift, "lk_shift");
            send_frame({1'b1, 8'hA5}, 9, 2, -1, "lk_bad");
        end
        tick();
        start_pulse(TErr, "lk_start");
        send_frame({1'b0, 8'hA5}, 9, 0, -1, "lk_load");
        tick();
        expect_probe(TErr, "lockout_hold");

        // Reset mid-shift, then a clean load of 0x01.
        do_reset("rst_5");
        start_pulse(TShift, "part_shift");
        send_frame({1'b0, 8'hFF}, 4, 0, -1, "part");
        do_reset("rst_mid");
        start_pulse(TShift, "01_shift");
        send_frame({1'b1, 8'h01}, 9, 1, -1, "01");
        tick();

        // ARMED ignores start and serial input.
        bus.start     = 1'b1;
        bus.ser_valid = 1'b1;
        bus.ser_data  = 1'b1;
        repeat (5) tick();
        bus.start     = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'b0;
        tick();
        expect_probe(tup(8'h01, 1'b1, 1'b0, 1'b0, 1'b0), "armed_hold");

        do_reset("rst_end");
        tick();
        expect_probe(TIdle, "idle_end");
        tick();
        tick();

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no output change, want %h", e.name, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 8: key width in bits delivered to the locked FSM.
REQ-002 Parameter TIMEOUT, default 64: maximum idle cycles between accepted bits while shifting.
REQ-003 Parameter MAX_RETRY, default 3: number of failed load attempts permitted before lockout.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  one-cycle request to begin a load.
REQ-007 ser_valid  in  1  a serial key bit is present on ser_data.
REQ-008 ser_data  in  1  serial key bit; key bits arrive LSB first, followed by one even-parity bit.
REQ-009 ser_ready  out  1  the block can accept a bit this cycle.
REQ-010 keyinput  out  KEY_W  key vector to the locked FSM's keyinput ports.
REQ-011 key_ok  out  1  keyinput is valid and stable.
REQ-012 fsm_rst  out  1  active-high hold/reset to the locked FSM; deasserts only when armed.
REQ-013 err  out  1  last attempt failed, or the block is locked out.

Function
REQ-014 The state machine SHALL have five states: IDLE, SHIFT, CHECK, ARMED, LOCKOUT; ERROR SHALL be a sixth state, entered from CHECK or SHIFT.
REQ-015 IDLE: start=1 SHALL go to SHIFT; bit count, shift register and timeout counter SHALL clear.
REQ-016 SHIFT: ser_ready=1; a bit SHALL be accepted on any cycle with ser_valid&&ser_ready, shifted into bit position count, and count incremented.
REQ-017 After KEY_W+1 accepted bits, SHIFT SHALL go to CHECK on the next edge with ser_ready=0; ser_ready SHALL be 0 in every state except SHIFT.
REQ-018 Timeout counter SHALL clear on each accepted bit and otherwise increment in SHIFT; reaching TIMEOUT SHALL go to ERROR.
REQ-019 CHECK (one cycle): XOR of the key bits equal to the parity bit SHALL go to ARMED, else ERROR.
REQ-020 Entering ARMED SHALL register the key into keyinput and set key_ok=1 and fsm_rst=0; ARMED is sticky until reset, and start and ser_valid SHALL be ignored.
REQ-021 Entering ERROR SHALL increment the retry counter and set err=1; keyinput SHALL remain 0.
REQ-022 In ERROR, start SHALL go to SHIFT with err cleared if retries < MAX_RETRY; otherwise the next edge SHALL go to LOCKOUT.
REQ-023 LOCKOUT: err=1, fsm_rst=1, key_ok=0, and all inputs ignored until reset.
REQ-024 start while in SHIFT or CHECK SHALL be ignored; it SHALL NOT restart the load.
REQ-025 Outside ARMED: fsm_rst=1, key_ok=0, keyinput=0.
REQ-026 Load latency from the last accepted bit to key_ok=1 SHALL be exactly 2 cycles.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE with keyinput=0, key_ok=0, fsm_rst=1, err=0, ser_ready=0, and all counters cleared.
REQ-028 Reset mid-SHIFT SHALL discard the partial key; reset SHALL be the only exit from ARMED and LOCKOUT.

Structure
REQ-029 The state encoding and the default values of KEY_W, TIMEOUT and MAX_RETRY SHALL live in a shared package, key_pkg.
REQ-030 The serial accumulator (shift register, bit counter, parity) SHALL be one sub-module, key_shift_rx; the FSM and counters SHALL stay in key_loader.

Verification
REQ-031 KEY_W=8, start, bits of 0xA5 LSB first then parity 0 -> keyinput=0xA5, key_ok=1, fsm_rst=0, two cycles after the last bit.
REQ-032 Key 0xA5 with parity 1 -> err=1, keyinput=0; then start and 0x3C with parity 0 -> ARMED, keyinput=0x3C, err=0.
REQ-033 Five bits delivered, then ser_valid=0 for 64 cycles -> ERROR, err=1, ser_ready=0.
REQ-034 Three consecutive bad-parity loads -> LOCKOUT; a subsequent valid load of 0xA5 -> no change, err=1, fsm_rst=1.
REQ-035 rst=0 after four bits, release, then a full valid load of 0x01 -> keyinput=0x01, with no residue from the earlier partial bits.
REQ-036 In ARMED, pulse start and drive ser_valid=1 -> keyinput, key_ok and fsm_rst unchanged.
